// File: rtl/mul_pipe_pkg.sv
// mul_pipe_pkg: shared widths for the 8-bit multiplier pipeline and its dot-product consumer
package mul_pipe_pkg;
  localparam int MUL_SIZE = 8;
  localparam int PROD_W = 2 * MUL_SIZE;
  localparam int DOT_LEN = 4;
  localparam int DOT_ACC_W = 18;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/mul_acc_outbuf.sv
// mul_acc_outbuf: one-entry valid/ready hold register with load, full flag and overrun strobe
//  load/din : new result offered this cycle
//  rdy      : downstream accepts the held entry
//  vld/dout : held entry (vld doubles as the full flag)
//  ovr      : load arrived while full and not draining; the new result is dropped
module mul_acc_outbuf #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic         vld,
  output logic [W-1:0] dout,
  output logic         ovr
);
  assign ovr = load & vld & ~rdy;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld <= 1'b0;
      dout <= '0;
    end else if (load & (~vld | rdy)) begin
      vld <= 1'b1;
      dout <= din;
    end else if (rdy) begin
      vld <= 1'b0;
    end
endmodule

// File: rtl/mul_dot_accum.sv
// mul_dot_accum: accumulates LEN valid products into one dot-product result behind a valid/ready buffer
//  prod_vld/prod : multiplier output, no backpressure
//  frame_clr     : abort the partial frame
//  out_rdy       : downstream accepts acc_out/acc_ovf while acc_vld
//  busy          : partial frame in progress
//  ovr_cnt       : saturating count of results dropped on overrun
module mul_dot_accum
  import mul_pipe_pkg::*;
#(
  parameter int IN_W  = PROD_W,
  parameter int ACC_W = DOT_ACC_W,
  parameter int LEN   = DOT_LEN,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prod_vld,
  input  logic [IN_W-1:0]  prod,
  input  logic             frame_clr,
  input  logic             out_rdy,
  output logic             acc_vld,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] ovr_cnt
);
  localparam int CW = clog2(LEN);
  logic [CW-1:0] count;
  logic [ACC_W-1:0] acc;
  logic ovf, ovf_now, last, ovr;
  logic [ACC_W:0] sum, bdata;
  // In IDLE the stale sum is masked off so a new frame starts from the product alone.
  assign sum = {1'b0, acc & {ACC_W{|count}}} + {1'b0, ACC_W'(prod)};
  assign ovf_now = (|count & ovf) | sum[ACC_W];
  assign last = prod_vld & ~frame_clr & (count == CW'(LEN - 1));
  assign busy = |count;
  assign {acc_ovf, acc_out} = bdata;
  always_ff @(posedge clk or posedge rst)
    if (rst | frame_clr) begin
      count <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (prod_vld) begin
      count <= last ? '0 : count + 1'b1;
      acc <= sum[ACC_W-1:0];
      ovf <= ovf_now;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) ovr_cnt <= '0;
    else ovr_cnt <= ovr_cnt + CNT_W'(ovr & ~&ovr_cnt);
  mul_acc_outbuf #(.W(ACC_W + 1)) u_buf (
    .clk(clk),
    .rst(rst),
    .load(last),
    .din({ovf_now, sum[ACC_W-1:0]}),
    .rdy(out_rdy),
    .vld(acc_vld),
    .dout(bdata),
    .ovr(ovr)
  );
endmodule

// File: tb/tb_mul_dot_accum.sv
// tb_mul_dot_accum: randomized and directed checks of mul_dot_accum (18-bit and 16-bit builds) against a frame-level model
module tb_mul_dot_accum;
  logic clk = 1'b0, rst = 1'b1;
  logic prod_vld = 1'b0, frame_clr = 1'b0, out_rdy = 1'b0;
  logic [15:0] prod = '0;
  logic acc_vld, acc_ovf, busy, acc_vld16, acc_ovf16, busy16;
  logic [17:0] acc_out;
  logic [15:0] acc_out16;
  logic [7:0] ovr_cnt, ovr_cnt16;
  int checks = 0, passed = 0;
  int unsigned frame[$];
  bit mvld;
  longint mtot;
  int movr;
  always #5 clk = ~clk;
  mul_dot_accum dut (
    .clk(clk), .rst(rst), .prod_vld(prod_vld), .prod(prod), .frame_clr(frame_clr),
    .out_rdy(out_rdy), .acc_vld(acc_vld), .acc_out(acc_out), .acc_ovf(acc_ovf),
    .busy(busy), .ovr_cnt(ovr_cnt)
  );
  mul_dot_accum #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .prod_vld(prod_vld), .prod(prod), .frame_clr(frame_clr),
    .out_rdy(out_rdy), .acc_vld(acc_vld16), .acc_out(acc_out16), .acc_ovf(acc_ovf16),
    .busy(busy16), .ovr_cnt(ovr_cnt16)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    else passed++;
  endtask
  task automatic compare();
    chk("vld", acc_vld, mvld);
    chk("vld16", acc_vld16, mvld);
    chk("busy", busy, frame.size() != 0);
    chk("busy16", busy16, frame.size() != 0);
    chk("ovr", ovr_cnt, movr);
    chk("ovr16", ovr_cnt16, movr);
    if (mvld) begin
      chk("out18", acc_out, mtot % (64'd1 << 18));
      chk("ovf18", acc_ovf, mtot >= (64'd1 << 18));
      chk("out16", acc_out16, mtot % (64'd1 << 16));
      chk("ovf16", acc_ovf16, mtot >= (64'd1 << 16));
    end
  endtask
  task automatic cyc(input bit v, input int p, input bit clr, input bit rdy);
    bit done = 0;
    longint tot = 0;
    prod_vld = v;
    prod = 16'(p);
    frame_clr = clr;
    out_rdy = rdy;
    @(posedge clk);
    if (clr) frame.delete();
    else if (v) begin
      frame.push_back(16'(p));
      if (frame.size() == 4) begin
        foreach (frame[i]) tot += frame[i];
        done = 1;
        frame.delete();
      end
    end
    if (done && (!mvld || rdy)) begin
      mvld = 1;
      mtot = tot;
    end else if (done) movr = (movr == 255) ? 255 : movr + 1;
    else if (rdy) mvld = 0;
    #1 compare();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #3;
    chk("rst_vld", acc_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr_cnt, 0);
    chk("rst_out", acc_out, 0);
    rst = 1'b0;
    frame.delete();
    mvld = 0;
    movr = 0;
  endtask
  initial begin
    do_reset();
    // basic frame, result held exactly one cycle
    cyc(1, 3, 0, 1); cyc(1, 5, 0, 1); cyc(1, 7, 0, 1); cyc(1, 9, 0, 1);
    chk("t2_sum", acc_out, 24);
    chk("t2_ovf", acc_ovf, 0);
    cyc(0, 0, 0, 1);
    chk("t2_drop", acc_vld, 0);
    // gaps, hold under out_rdy=0, 16-bit wrap
    for (int i = 0; i < 4; i++) begin
      cyc(1, 65025, 0, 0);
      cyc(0, 0, 0, 0);
    end
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    chk("t3_sum", acc_out, 260100);
    chk("t6_out16", acc_out16, 63492);
    chk("t6_ovf16", acc_ovf16, 1);
    cyc(0, 0, 0, 1);
    chk("t3_drop", acc_vld, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
    chk("t6_clean", acc_ovf16, 0);
    cyc(0, 0, 0, 1);
    // overrun, then same-cycle replace
    cyc(1, 3, 0, 0); cyc(1, 5, 0, 0); cyc(1, 7, 0, 0); cyc(1, 9, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    chk("t4_hold", acc_out, 24);
    chk("t4_ovr", ovr_cnt, 1);
    cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 1);
    chk("t4_new", acc_out, 8);
    chk("t4_vld", acc_vld, 1);
    chk("t4_ovr2", ovr_cnt, 1);
    cyc(0, 0, 0, 1);
    // frame_clr discards partial frame and same-cycle product
    cyc(1, 10, 0, 1); cyc(1, 20, 0, 1); cyc(1, 30, 1, 1);
    chk("t5_busy", busy, 0);
    cyc(1, 1, 0, 1); cyc(1, 2, 0, 1); cyc(1, 3, 0, 1); cyc(1, 4, 0, 1);
    chk("t5_sum", acc_out, 10);
    cyc(0, 0, 0, 1);
    // reset mid-frame with buffer full and nonzero overrun count
    for (int i = 0; i < 4; i++) cyc(1, 7, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    cyc(1, 100, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 5, 0, 0);
    chk("t1_sum", acc_out, 20);
    cyc(0, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 255) * $urandom_range(0, 255),
          $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
